// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// mult_share_arbiter : round-robin arbiter sharing one multi-cycle 16x16 mult
// Revision 1.0
// ============================================================================
module mult_share_arbiter #(
  parameter int NREQ         = 4,
  parameter int MULT_LATENCY = 34
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [31:0]        rsp_product,
  input  logic               rsp_ready,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  output logic               mul_start,
  output logic               mul_reset,
  input  logic [31:0]        mul_product,
  output logic               busy
);

  localparam logic [7:0] CNT_LAST = 8'(MULT_LATENCY - 1);
  localparam logic [2:0] PTR_INIT = 3'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  ptr;
  logic [7:0]  cnt;
  logic [2:0]  grant_idx;
  logic [2:0]  hi_idx;
  logic [2:0]  lo_idx;
  logic        hi_found;
  logic        lo_found;
  logic        grant;
  logic [15:0] sel_a;
  logic [15:0] sel_b;

  // Lowest requester above ptr wins; otherwise wrap to the lowest at or below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = 3'd0;
    lo_idx   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !hi_found && (3'(i) > ptr)) begin
        hi_found = 1'b1;
        hi_idx   = 3'(i);
      end
      if (req_valid[i] && !lo_found && (3'(i) <= ptr)) begin
        lo_found = 1'b1;
        lo_idx   = 3'(i);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant     = (state == IDLE) && !reset && (hi_found || lo_found);
  end

  always_comb begin
    sel_a     = 16'd0;
    sel_b     = 16'd0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == grant_idx) begin
        sel_a        = req_a[16*i +: 16];
        sel_b        = req_b[16*i +: 16];
        req_ready[i] = grant;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    mul_start = 1'b0;
    mul_reset = reset;
    busy      = 1'b0;
    case (state)
      IDLE:   if (grant) state_nxt = CLR;
      CLR:    state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT;
      WAIT:   if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!reset) begin
      busy      = (state != IDLE);
      rsp_valid = (state == RESP);
      mul_start = (state == LAUNCH);
      mul_reset = (state == CLR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= PTR_INIT;
      cnt         <= 8'd0;
      mul_a       <= 16'd0;
      mul_b       <= 16'd0;
      rsp_id      <= 3'd0;
      rsp_product <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        mul_a  <= sel_a;
        mul_b  <= sel_b;
        rsp_id <= grant_idx;
        ptr    <= grant_idx;
      end
      if (state == LAUNCH) begin
        cnt <= 8'd0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      // The multiplier output is valid in the final WAIT cycle.
      if ((state == WAIT) && (cnt == CNT_LAST)) begin
        rsp_product <= mul_product;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requester ports (2..8).
REQ-002 The block SHALL have parameter MULT_LATENCY, default 34, meaning the number of clock cycles from the mul_start cycle to a valid mul_product (1..255).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ bits: bit i high means requester i presents an operand pair.
REQ-006 Port req_a, input, 16*NREQ bits: packed multiplicand a; requester i occupies bits [16i+15:16i].
REQ-007 Port req_b, input, 16*NREQ bits: packed multiplier b, packed the same way as req_a.
REQ-008 Port req_ready, output, NREQ bits: one-hot grant/accept strobe.
REQ-009 Port rsp_valid, output, 1 bit: a result is presented.
REQ-010 Port rsp_id, output, 3 bits: index of the requester that owns the result.
REQ-011 Port rsp_product, output, 32 bits: the unsigned product.
REQ-012 Port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port mul_a, output, 16 bits: registered operand to the shared multiplier_16bit.
REQ-014 Port mul_b, output, 16 bits: registered operand to the shared multiplier_16bit.
REQ-015 Port mul_start, output, 1 bit: one-cycle start pulse to the multiplier.
REQ-016 Port mul_reset, output, 1 bit: clear pulse to the multiplier.
REQ-017 Port mul_product, input, 32 bits: product from the multiplier.
REQ-018 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, CLR, LAUNCH, WAIT and RESP, and only these states.
REQ-020 In IDLE with any req_valid bit set, the block SHALL grant the first set bit found in round-robin order starting at ptr+1 (mod NREQ), SHALL drive req_ready[g]=1 combinationally that cycle, and SHALL latch req_a/req_b slice g into mul_a/mul_b, g into rsp_id, and g into ptr.
REQ-021 The block SHALL assert at most one req_ready bit at a time, and only in IDLE; req_ready SHALL be all zeros in every other state.
REQ-022 Transitions: IDLE->CLR on grant; CLR->LAUNCH unconditionally; LAUNCH->WAIT unconditionally; WAIT->RESP when cnt==MULT_LATENCY-1; RESP->IDLE when rsp_ready is high.
REQ-023 mul_reset SHALL be 1 only in CLR and while reset is high; mul_start SHALL be 1 only in LAUNCH.
REQ-024 cnt SHALL be 8 bits, cleared in LAUNCH and incremented in WAIT; on the WAIT exit edge the block SHALL register mul_product into rsp_product.
REQ-025 Latency: for a grant in cycle T, mul_start SHALL be high in T+2 and rsp_valid SHALL first be high in T+3+MULT_LATENCY.
REQ-026 rsp_valid SHALL be high exactly in RESP.
REQ-027 rsp_product and rsp_id SHALL hold stable while rsp_valid=1 and rsp_ready=0 (backpressure, unbounded).
REQ-028 No new grant SHALL occur in the cycle rsp_valid&rsp_ready completes; the earliest next grant SHALL be one cycle later (IDLE).
REQ-029 The block SHALL ignore req_valid changes and req_a/req_b changes outside the grant cycle.
REQ-030 A requester that drops req_valid before being granted SHALL simply lose its turn, with no error.
REQ-031 rsp_product SHALL equal the 32-bit unsigned a*b with no truncation; 0xFFFF*0xFFFF=0xFFFE0001.

Reset
REQ-032 With reset high, at the next edge the block SHALL set state=IDLE, ptr=NREQ-1 (requester 0 has first priority), cnt=0, mul_a=0, mul_b=0, rsp_id=0, rsp_product=0.
REQ-033 During reset the outputs SHALL be rsp_valid=0, req_ready=0, mul_start=0, busy=0, mul_reset=1.
REQ-034 Reset asserted in any state (mid-WAIT or mid-RESP) SHALL abort the operation; the pending result SHALL be discarded, with no response issued.

Verification
REQ-035 Single request: req_valid=0001, a=10, b=20 -> req_ready=0001 for one cycle, mul_start at T+2, rsp_valid at T+37, rsp_id=0, rsp_product=200.
REQ-036 Back-to-back on one port: requester 2 sends 100*25, then 1234*5678 -> products 2500 and 7006652 in order, each with rsp_id=2, and no grant in the handshake cycle.
REQ-037 Fairness: req_valid=1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3, each rsp_id matching its grant.
REQ-038 Backpressure: rsp_ready held low 10 cycles after rsp_valid -> rsp_product/rsp_id stable, req_ready=0, busy=1 throughout, then the next grant follows one cycle after the handshake.
REQ-039 Boundary: 65535*65535 -> 4294836225; 0*40000 -> 0.
REQ-040 Reset mid-WAIT (cycle T+20): rsp_valid never asserts for that request, mul_reset=1 during reset, and a subsequent 3*7 request from requester 1 returns 21 with rsp_id=1.
